// File: rtl/reg_bus_pkg.sv
// Shared definitions for the register-file access port: bus widths, the
// arbiter state encoding and register addresses used by the bus masters.
package reg_bus_pkg;

    localparam int unsigned NUM_REQ  = 3;
    localparam int unsigned ADDR_W   = 6;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned MAX_ADDR = 56;
    localparam int unsigned LOCK_MAX = 4;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StCapture,
        StResp
    } bus_state_e;

    // Addresses 1-3 are broadcast registers fanned out by reg_file.
    localparam logic [ADDR_W-1:0] RegAddrId      = 6'h00;
    localparam logic [ADDR_W-1:0] RegAddrBcastLo = 6'h01;
    localparam logic [ADDR_W-1:0] RegAddrBcastHi = 6'h03;
    localparam logic [ADDR_W-1:0] RegAddrCtrl    = 6'h04;
    localparam logic [ADDR_W-1:0] RegAddrAngle   = 6'h10;
    localparam logic [ADDR_W-1:0] RegAddrWdog    = 6'h20;
    localparam logic [ADDR_W-1:0] RegAddrLast    = 6'h38;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request strictly after the
// pointer, searching upward with wrap; the pointer slot itself is checked last.
module rr_picker #(
    parameter int unsigned N    = 3,
    parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [IdxW-1:0] idx,
    output logic            valid
);

    always_comb begin
        int unsigned c;
        c     = 0;
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        for (int unsigned i = 1; i <= N; i++) begin
            c = (32'(ptr) + i) % N;
            if (!valid && req[c]) begin
                valid    = 1'b1;
                grant[c] = 1'b1;
                idx      = IdxW'(c);
            end
        end
    end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing the single reg_file access port between bus
// masters, with a bounded ownership lock and out-of-range address rejection.
module reg_bus_arbiter #(
    parameter int unsigned NUM_REQ  = reg_bus_pkg::NUM_REQ,
    parameter int unsigned ADDR_W   = reg_bus_pkg::ADDR_W,
    parameter int unsigned DATA_W   = reg_bus_pkg::DATA_W,
    parameter int unsigned MAX_ADDR = reg_bus_pkg::MAX_ADDR,
    parameter int unsigned LOCK_MAX = reg_bus_pkg::LOCK_MAX
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      err,
    output logic [DATA_W-1:0]         rdata,
    output logic [NUM_REQ-1:0]        grant,
    output logic [ADDR_W-1:0]         bus_addr,
    output logic                      bus_write_en,
    output logic [DATA_W-1:0]         bus_wr_data,
    output logic                      bus_read_en,
    input  logic [DATA_W-1:0]         bus_rd_data
);

    import reg_bus_pkg::*;

    localparam int unsigned IdxW = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(LOCK_MAX + 1);

    bus_state_e         state_q, state_d;
    logic [IdxW-1:0]    ptr_q, ptr_d;
    logic [IdxW-1:0]    owner_q, owner_d;
    logic [IdxW-1:0]    lock_owner_q, lock_owner_d;
    logic               lock_valid_q, lock_valid_d;
    logic [CntW-1:0]    lock_cnt_q, lock_cnt_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               we_q, we_d;
    logic               lock_q, lock_d;
    logic               legal_q, legal_d;

    logic [NUM_REQ-1:0] pick_grant;
    logic [IdxW-1:0]    pick_idx;
    logic               any_req;
    logic               lock_hit;
    logic [NUM_REQ-1:0] lock_onehot;
    logic [IdxW-1:0]    win_idx;
    logic [ADDR_W-1:0]  win_addr;

    rr_picker #(
        .N    (NUM_REQ),
        .IdxW (IdxW)
    ) u_picker (
        .req   (req),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .valid (any_req)
    );

    always_comb begin
        lock_hit = lock_valid_q && req[lock_owner_q] && (lock_cnt_q < CntW'(LOCK_MAX));
        lock_onehot = '0;
        lock_onehot[lock_owner_q] = 1'b1;
        win_idx  = lock_hit ? lock_owner_q : pick_idx;
        win_addr = req_addr[win_idx*ADDR_W +: ADDR_W];
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        lock_owner_d = lock_owner_q;
        lock_valid_d = lock_valid_q;
        lock_cnt_d   = lock_cnt_q;
        grant_d      = grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        we_d         = we_q;
        lock_d       = lock_q;
        legal_d      = legal_q;

        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d = StIssue;
                    ptr_d   = win_idx;
                    owner_d = win_idx;
                    grant_d = lock_hit ? lock_onehot : pick_grant;
                    addr_d  = win_addr;
                    wdata_d = req_wdata[win_idx*DATA_W +: DATA_W];
                    we_d    = req_we[win_idx];
                    lock_d  = req_lock[win_idx];
                    legal_d = 32'(win_addr) <= MAX_ADDR;
                    // An exhausted lock has just been skipped; its budget restarts.
                    if (lock_valid_q && lock_cnt_q >= CntW'(LOCK_MAX)) begin
                        lock_cnt_d = '0;
                    end
                end
            end
            StIssue: begin
                state_d = StCapture;
            end
            StCapture: begin
                state_d = StResp;
                if (!we_q) begin
                    rdata_d = legal_q ? bus_rd_data : '0;
                end
            end
            StResp: begin
                state_d = StIdle;
                grant_d = '0;
                if (lock_q) begin
                    lock_valid_d = 1'b1;
                    lock_owner_d = owner_q;
                    // A new lock holder starts its own count of consecutive grants.
                    lock_cnt_d   = (lock_valid_q && lock_owner_q == owner_q) ?
                                   lock_cnt_q + 1'b1 : CntW'(1);
                end else begin
                    lock_valid_d = 1'b0;
                    lock_cnt_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            ptr_q        <= IdxW'(NUM_REQ - 1);
            owner_q      <= '0;
            lock_owner_q <= '0;
            lock_valid_q <= 1'b0;
            lock_cnt_q   <= '0;
            grant_q      <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            we_q         <= 1'b0;
            lock_q       <= 1'b0;
            legal_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            lock_owner_q <= lock_owner_d;
            lock_valid_q <= lock_valid_d;
            lock_cnt_q   <= lock_cnt_d;
            grant_q      <= grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            we_q         <= we_d;
            lock_q       <= lock_d;
            legal_q      <= legal_d;
        end
    end

    assign grant        = grant_q;
    assign ack          = (state_q == StResp) ? grant_q : '0;
    assign err          = (state_q == StResp) && !legal_q;
    assign rdata        = rdata_q;
    assign bus_addr     = addr_q;
    assign bus_wr_data  = wdata_q;
    assign bus_write_en = (state_q == StIssue) && we_q && legal_q;
    assign bus_read_en  = (state_q == StIssue) && !we_q && legal_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter with a small behavioural reg_file model.
module tb_reg_bus_arbiter;

    localparam int unsigned NR = 3;
    localparam int unsigned AW = 6;
    localparam int unsigned DW = 8;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [NR-1:0]     req = '0;
    logic [NR-1:0]     req_we = '0;
    logic [NR-1:0]     req_lock = '0;
    logic [NR*AW-1:0]  req_addr = '0;
    logic [NR*DW-1:0]  req_wdata = '0;
    logic [NR-1:0]     ack;
    logic              err;
    logic [DW-1:0]     rdata;
    logic [NR-1:0]     grant;
    logic [AW-1:0]     bus_addr;
    logic              bus_write_en;
    logic [DW-1:0]     bus_wr_data;
    logic              bus_read_en;
    logic [DW-1:0]     bus_rd_data = '0;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] mem [0:63];
    logic          rf_loaded = 1'b0;

    always #5 clock = ~clock;

    reg_bus_arbiter #(
        .NUM_REQ  (NR),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .MAX_ADDR (56),
        .LOCK_MAX (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .req_we       (req_we),
        .req_lock     (req_lock),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .ack          (ack),
        .err          (err),
        .rdata        (rdata),
        .grant        (grant),
        .bus_addr     (bus_addr),
        .bus_write_en (bus_write_en),
        .bus_wr_data  (bus_wr_data),
        .bus_read_en  (bus_read_en),
        .bus_rd_data  (bus_rd_data)
    );

    // reg_file model: registered read data one cycle after read_en.
    always @(posedge clock) begin
        if (!rf_loaded) begin
            for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
            mem[6'h0F] <= 8'hA5;
            mem[6'h10] <= 8'h61;
            mem[6'h11] <= 8'h72;
            mem[6'h12] <= 8'h83;
            mem[6'h38] <= 8'h5C;
            rf_loaded  <= 1'b1;
        end else begin
            if (bus_write_en) mem[bus_addr] <= bus_wr_data;
            if (bus_read_en) bus_rd_data <= mem[bus_addr];
        end
    end

    task automatic step();
        @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_master(input int i, input logic we, input logic lock,
                              input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        req_we[i]              = we;
        req_lock[i]            = lock;
        req_addr[i*AW +: AW]   = addr;
        req_wdata[i*DW +: DW]  = wd;
    endtask

    initial begin
        logic [DW-1:0] cont_rd [3];
        logic [NR-1:0] lock_gnt [7];
        logic [NR-1:0] exp_g;
        cont_rd  = '{8'h61, 8'h72, 8'h83};
        lock_gnt = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b100, 3'b100};

        // Reset state
        step(); step();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_rdata", 32'(rdata), 32'h0);
        check("rst_bus_addr", 32'(bus_addr), 32'h0);
        check("rst_bus_wr_data", 32'(bus_wr_data), 32'h0);
        check("rst_write_en", 32'(bus_write_en), 32'h0);
        check("rst_read_en", 32'(bus_read_en), 32'h0);
        reset = 1'b0;
        step();

        // Single read from master 0
        set_master(0, 1'b0, 1'b0, 6'h0F, 8'h00);
        req = 3'b001;
        step();
        check("rd_grant", 32'(grant), 32'h1);
        check("rd_read_en", 32'(bus_read_en), 32'h1);
        check("rd_write_en", 32'(bus_write_en), 32'h0);
        check("rd_addr", 32'(bus_addr), 32'h0F);
        req = 3'b000;
        step();
        check("rd_read_en_n2", 32'(bus_read_en), 32'h0);
        check("rd_ack_n2", 32'(ack), 32'h0);
        step();
        check("rd_ack", 32'(ack), 32'h1);
        check("rd_err", 32'(err), 32'h0);
        check("rd_rdata", 32'(rdata), 32'hA5);
        step();
        check("rd_ack_idle", 32'(ack), 32'h0);
        check("rd_grant_idle", 32'(grant), 32'h0);

        // Single write from master 1
        set_master(1, 1'b1, 1'b0, 6'h04, 8'hC3);
        req = 3'b010;
        step();
        check("wr_grant", 32'(grant), 32'h2);
        check("wr_write_en", 32'(bus_write_en), 32'h1);
        check("wr_read_en", 32'(bus_read_en), 32'h0);
        check("wr_addr", 32'(bus_addr), 32'h04);
        check("wr_wdata", 32'(bus_wr_data), 32'hC3);
        req = 3'b000;
        step();
        check("wr_write_en_n2", 32'(bus_write_en), 32'h0);
        step();
        check("wr_ack", 32'(ack), 32'h2);
        check("wr_err", 32'(err), 32'h0);
        check("wr_rdata_held", 32'(rdata), 32'hA5);
        step();

        // Contention from a fresh pointer: order 0,1,2,0,1,2
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_master(0, 1'b0, 1'b0, 6'h10, 8'h00);
        set_master(1, 1'b0, 1'b0, 6'h11, 8'h00);
        set_master(2, 1'b0, 1'b0, 6'h12, 8'h00);
        req = 3'b111;
        for (int k = 0; k < 6; k++) begin
            exp_g = 3'b001 << (k % 3);
            step();
            check($sformatf("ct_grant_%0d", k), 32'(grant), 32'(exp_g));
            step();
            check($sformatf("ct_ack_n2_%0d", k), 32'(ack), 32'h0);
            step();
            check($sformatf("ct_ack_%0d", k), 32'(ack), 32'(exp_g));
            check($sformatf("ct_rdata_%0d", k), 32'(rdata), 32'(cont_rd[k % 3]));
            if (k == 5) req = 3'b000;
            step();
            check($sformatf("ct_idle_ack_%0d", k), 32'(ack), 32'h0);
        end

        // Lock bound: four grants to 2, forced rotation to 0, lock again
        set_master(2, 1'b0, 1'b1, 6'h12, 8'h00);
        set_master(0, 1'b0, 1'b0, 6'h10, 8'h00);
        req = 3'b100;
        for (int k = 0; k < 7; k++) begin
            step();
            check($sformatf("lk_grant_%0d", k), 32'(grant), 32'(lock_gnt[k]));
            if (k == 0) req = 3'b101;
            if (k == 6) req = 3'b000;
            step();
            step();
            check($sformatf("lk_ack_%0d", k), 32'(ack), 32'(lock_gnt[k]));
            check($sformatf("lk_rdata_%0d", k), 32'(rdata),
                  (lock_gnt[k] == 3'b001) ? 32'h61 : 32'h83);
            step();
        end
        req_lock = 3'b000;

        // Illegal read 0x3A
        set_master(0, 1'b0, 1'b0, 6'h3A, 8'h00);
        req = 3'b001;
        step();
        check("il_grant", 32'(grant), 32'h1);
        check("il_read_en", 32'(bus_read_en), 32'h0);
        check("il_write_en", 32'(bus_write_en), 32'h0);
        req = 3'b000;
        step();
        step();
        check("il_ack", 32'(ack), 32'h1);
        check("il_err", 32'(err), 32'h1);
        check("il_rdata", 32'(rdata), 32'h0);
        step();
        check("il_err_idle", 32'(err), 32'h0);

        // Highest legal address 0x38
        set_master(1, 1'b0, 1'b0, 6'h38, 8'h00);
        req = 3'b010;
        step();
        check("mx_read_en", 32'(bus_read_en), 32'h1);
        req = 3'b000;
        step();
        step();
        check("mx_ack", 32'(ack), 32'h2);
        check("mx_err", 32'(err), 32'h0);
        check("mx_rdata", 32'(rdata), 32'h5C);
        step();

        // Illegal write 0x39
        set_master(2, 1'b1, 1'b0, 6'h39, 8'hEE);
        req = 3'b100;
        step();
        check("iw_grant", 32'(grant), 32'h4);
        check("iw_write_en", 32'(bus_write_en), 32'h0);
        req = 3'b000;
        step();
        step();
        check("iw_ack", 32'(ack), 32'h4);
        check("iw_err", 32'(err), 32'h1);
        check("iw_rdata", 32'(rdata), 32'h5C);
        step();

        // Reset during CAPTURE
        set_master(0, 1'b0, 1'b0, 6'h0F, 8'h00);
        req = 3'b001;
        step();
        check("ro_read_en", 32'(bus_read_en), 32'h1);
        step();
        reset = 1'b1;
        req   = 3'b000;
        step();
        check("ro_grant", 32'(grant), 32'h0);
        check("ro_ack", 32'(ack), 32'h0);
        check("ro_err", 32'(err), 32'h0);
        check("ro_rdata", 32'(rdata), 32'h0);
        check("ro_bus_addr", 32'(bus_addr), 32'h0);
        check("ro_read_en_off", 32'(bus_read_en), 32'h0);
        reset = 1'b0;
        step();
        check("ro_ack_late", 32'(ack), 32'h0);

        // Master 1 alone after reset reads back the earlier write
        set_master(1, 1'b0, 1'b0, 6'h04, 8'h00);
        req = 3'b010;
        step();
        check("ra_grant", 32'(grant), 32'h2);
        check("ra_read_en", 32'(bus_read_en), 32'h1);
        req = 3'b000;
        step();
        step();
        check("ra_ack", 32'(ack), 32'h2);
        check("ra_rdata", 32'(rdata), 32'hC3);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
